// File: rtl/lcd_image_ctrl_if.sv
// Bus bundle between the image controller and its environment.
// Carries the command handshake (cmd, cmd_valid, busy, done), the image ROM
// read port (IROM_rd, IROM_A, IROM_Q) and the result RAM write port
// (IRAM_valid, IRAM_A, IRAM_D).
//   master : controller side (drives busy/done and both memory address buses)
//   slave  : environment side (command source plus ROM/RAM models)
interface lcd_image_ctrl_if;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       done;
  logic       IROM_rd;
  logic [5:0] IROM_A;
  logic [7:0] IROM_Q;
  logic       IRAM_valid;
  logic [7:0] IRAM_D;
  logic [5:0] IRAM_A;

  modport master (
    input  cmd, cmd_valid, IROM_Q,
    output busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A
  );

  modport slave (
    output cmd, cmd_valid, IROM_Q,
    input  busy, done, IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A
  );
endinterface

// File: rtl/lcd_image_ctrl.sv
// 8x8 grayscale image controller.
// Loads 64 pixels from IROM into an internal buffer, executes 4-bit commands
// on the 2x2 window around a movable operation point (x,y), and on Write
// dumps the buffer to IRAM and pulses done.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - lcd_image_ctrl_if.master (command handshake, IROM read, IRAM write)
module lcd_image_ctrl (
  input  logic                clk,
  input  logic                reset,
  lcd_image_ctrl_if.master    bus
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CRD_W  = 3;
  localparam int unsigned SUM_W  = 10;
  localparam int unsigned NPIX   = 64;

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  // Registered state and outputs
  state_t              r_state;
  logic [3:0]          r_cmd;
  logic [CRD_W-1:0]    r_x;
  logic [CRD_W-1:0]    r_y;
  logic                r_rom_rd;
  logic [ADDR_W-1:0]   r_rom_a;
  logic                r_ram_valid;
  logic [PIX_W-1:0]    r_ram_d;
  logic [ADDR_W-1:0]   r_ram_a;
  logic                r_busy;
  logic                r_done;
  logic [PIX_W-1:0]    r_buf [NPIX];

  // Next-state values
  state_t              w_state_nxt;
  logic [3:0]          w_cmd_nxt;
  logic [CRD_W-1:0]    w_x_nxt;
  logic [CRD_W-1:0]    w_y_nxt;
  logic                w_rom_rd_nxt;
  logic [ADDR_W-1:0]   w_rom_a_nxt;
  logic                w_ram_valid_nxt;
  logic [PIX_W-1:0]    w_ram_d_nxt;
  logic [ADDR_W-1:0]   w_ram_a_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_ld_we;
  logic                w_win_we;

  // Window addressing and datapath
  logic [CRD_W-1:0]    w_xm1;
  logic [CRD_W-1:0]    w_ym1;
  logic [ADDR_W-1:0]   w_i_tl, w_i_tr, w_i_bl, w_i_br;
  logic [PIX_W-1:0]    w_p_tl, w_p_tr, w_p_bl, w_p_br;
  logic [PIX_W-1:0]    w_n_tl, w_n_tr, w_n_bl, w_n_br;
  logic [PIX_W-1:0]    w_max_t, w_max_b, w_max;
  logic [PIX_W-1:0]    w_min_t, w_min_b, w_min;
  logic [SUM_W-1:0]    w_sum;
  logic [PIX_W-1:0]    w_avg;
  logic [ADDR_W-1:0]   w_ram_a_inc;

  assign w_xm1  = r_x - CRD_W'(1);
  assign w_ym1  = r_y - CRD_W'(1);
  assign w_i_tl = {w_ym1, w_xm1};
  assign w_i_tr = {w_ym1, r_x};
  assign w_i_bl = {r_y,   w_xm1};
  assign w_i_br = {r_y,   r_x};

  assign w_p_tl = r_buf[w_i_tl];
  assign w_p_tr = r_buf[w_i_tr];
  assign w_p_bl = r_buf[w_i_bl];
  assign w_p_br = r_buf[w_i_br];

  assign w_max_t = (w_p_tl > w_p_tr) ? w_p_tl : w_p_tr;
  assign w_max_b = (w_p_bl > w_p_br) ? w_p_bl : w_p_br;
  assign w_max   = (w_max_t > w_max_b) ? w_max_t : w_max_b;
  assign w_min_t = (w_p_tl < w_p_tr) ? w_p_tl : w_p_tr;
  assign w_min_b = (w_p_bl < w_p_br) ? w_p_bl : w_p_br;
  assign w_min   = (w_min_t < w_min_b) ? w_min_t : w_min_b;

  assign w_sum = SUM_W'(w_p_tl) + SUM_W'(w_p_tr) + SUM_W'(w_p_bl) + SUM_W'(w_p_br);
  assign w_avg = w_sum[SUM_W-1:2];

  assign w_ram_a_inc = r_ram_a + ADDR_W'(1);

  // New window contents for the latched pixel command
  always_comb begin
    w_n_tl = w_p_tl;
    w_n_tr = w_p_tr;
    w_n_bl = w_p_bl;
    w_n_br = w_p_br;
    case (r_cmd)
      4'h5: begin w_n_tl = w_max; w_n_tr = w_max; w_n_bl = w_max; w_n_br = w_max; end
      4'h6: begin w_n_tl = w_min; w_n_tr = w_min; w_n_bl = w_min; w_n_br = w_min; end
      4'h7: begin w_n_tl = w_avg; w_n_tr = w_avg; w_n_bl = w_avg; w_n_br = w_avg; end
      4'h8: begin w_n_tl = w_p_tr; w_n_tr = w_p_br; w_n_bl = w_p_tl; w_n_br = w_p_bl; end
      4'h9: begin w_n_tl = w_p_bl; w_n_tr = w_p_tl; w_n_bl = w_p_br; w_n_br = w_p_tr; end
      4'hA: begin w_n_tl = w_p_bl; w_n_tr = w_p_br; w_n_bl = w_p_tl; w_n_br = w_p_tr; end
      4'hB: begin w_n_tl = w_p_tr; w_n_tr = w_p_tl; w_n_bl = w_p_br; w_n_br = w_p_bl; end
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_rom_rd_nxt    = r_rom_rd;
    w_rom_a_nxt     = r_rom_a;
    w_ram_valid_nxt = r_ram_valid;
    w_ram_d_nxt     = r_ram_d;
    w_ram_a_nxt     = r_ram_a;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_ld_we         = 1'b0;
    w_win_we        = 1'b0;

    case (r_state)
      // First cycle raises the read strobe; each later edge stores the byte
      // the ROM registered on the preceding falling edge.
      S_LOAD: begin
        if (!r_rom_rd) begin
          w_rom_rd_nxt = 1'b1;
        end else begin
          w_ld_we = 1'b1;
          if (r_rom_a == ADDR_W'(NPIX - 1)) begin
            w_rom_rd_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_rom_a_nxt = r_rom_a + ADDR_W'(1);
          end
        end
      end

      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_cmd_nxt   = bus.cmd;
          w_busy_nxt  = 1'b1;
          w_state_nxt = (bus.cmd == 4'h0) ? S_WRITE : S_EXEC;
        end
      end

      S_EXEC: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
        case (r_cmd)
          4'h1: if (r_y > CRD_W'(1)) w_y_nxt = r_y - CRD_W'(1);
          4'h2: if (r_y < CRD_W'(7)) w_y_nxt = r_y + CRD_W'(1);
          4'h3: if (r_x > CRD_W'(1)) w_x_nxt = r_x - CRD_W'(1);
          4'h4: if (r_x < CRD_W'(7)) w_x_nxt = r_x + CRD_W'(1);
          4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: w_win_we = 1'b1;
          default: ;
        endcase
      end

      // First cycle presents address 0; then one pixel per cycle to 63.
      S_WRITE: begin
        if (!r_ram_valid) begin
          w_ram_valid_nxt = 1'b1;
          w_ram_a_nxt     = '0;
          w_ram_d_nxt     = r_buf[0];
        end else if (r_ram_a == ADDR_W'(NPIX - 1)) begin
          w_ram_valid_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_ram_a_nxt = w_ram_a_inc;
          w_ram_d_nxt = r_buf[w_ram_a_inc];
        end
      end

      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_LOAD;
      r_cmd       <= 4'h0;
      r_x         <= CRD_W'(4);
      r_y         <= CRD_W'(4);
      r_rom_rd    <= 1'b0;
      r_rom_a     <= '0;
      r_ram_valid <= 1'b0;
      r_ram_d     <= '0;
      r_ram_a     <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_rom_rd    <= w_rom_rd_nxt;
      r_rom_a     <= w_rom_a_nxt;
      r_ram_valid <= w_ram_valid_nxt;
      r_ram_d     <= w_ram_d_nxt;
      r_ram_a     <= w_ram_a_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Pixel buffer; contents are don't-care after reset so no reset branch
  always_ff @(posedge clk) begin
    if (w_ld_we) r_buf[r_rom_a] <= bus.IROM_Q;
    if (w_win_we) begin
      r_buf[w_i_tl] <= w_n_tl;
      r_buf[w_i_tr] <= w_n_tr;
      r_buf[w_i_bl] <= w_n_bl;
      r_buf[w_i_br] <= w_n_br;
    end
  end

  assign bus.IROM_rd    = r_rom_rd;
  assign bus.IROM_A     = r_rom_a;
  assign bus.IRAM_valid = r_ram_valid;
  assign bus.IRAM_D     = r_ram_d;
  assign bus.IRAM_A     = r_ram_a;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_lcd_image_ctrl.sv
// Scoreboard bench for lcd_image_ctrl: ROM/RAM models, directed commands with
// hand-computed window results, and a negedge monitor that checks every RAM
// write and done pulse against queued expectations.
module tb_lcd_image_ctrl;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_image_ctrl_if bus ();

  lcd_image_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rom     [64];
  logic [7:0] ram     [64];
  logic [7:0] exp_img [64];
  wr_t        exp_q   [$];
  wr_t        mon_e;
  int         total = 0;
  int         bad = 0;
  int         done_seen = 0;
  logic       prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // ROM registers its output on the falling edge while read is enabled
  always @(negedge clk) begin
    if (bus.IROM_rd) bus.IROM_Q <= rom[bus.IROM_A];
  end

  // RAM model plus scoreboard monitor
  always @(negedge clk) begin
    if (bus.IRAM_valid) begin
      ram[bus.IRAM_A] = bus.IRAM_D;
      if (exp_q.size() == 0) begin
        check("ram_unexpected", 32'({bus.IRAM_A, bus.IRAM_D}), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("ram_wr", 32'({bus.IRAM_A, bus.IRAM_D}), 32'({mon_e.a, mon_e.d}));
      end
    end
    if (bus.done) begin
      done_seen++;
      check("done_after_last", 32'(exp_q.size()), 32'd0);
    end
    if (prev_done) check("done_width", 32'(bus.done), 32'd0);
    prev_done = bus.done;
  end

  // Release reset and follow the 65-cycle load
  task automatic do_load();
    int n = 0;
    int k = 0;
    @(negedge clk);
    reset = 1'b1;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check("rd_first", 32'(bus.IROM_rd), 32'd1);
      if (bus.IROM_rd) begin
        check("rom_addr", 32'(bus.IROM_A), 32'(k));
        k++;
      end
      if (!bus.busy) break;
    end
    check("load_cycles", 32'(n), 32'd65);
    check("load_count", 32'(k), 32'd64);
    check("rd_after_load", 32'(bus.IROM_rd), 32'd0);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < 500), 32'd1);
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("busy_accept", 32'(bus.busy), 32'd1);
    if (c != 4'h0) begin
      @(posedge clk);
      #1;
      check("exec_one_cycle", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic shift(input logic [3:0] c, input int times);
    for (int i = 0; i < times; i++) send_cmd(c);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < 200), 32'd1);
    check("busy_in_done", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic write_expect();
    for (int i = 0; i < 64; i++) exp_q.push_back('{a: 6'(i), d: exp_img[i]});
    send_cmd(4'h0);
    wait_done();
  endtask

  task automatic set4(input int i0, input int i1, input int i2, input int i3,
                      input logic [7:0] v0, input logic [7:0] v1,
                      input logic [7:0] v2, input logic [7:0] v3);
    exp_img[i0] = v0; exp_img[i1] = v1; exp_img[i2] = v2; exp_img[i3] = v3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dsave;
    for (int i = 0; i < 64; i++) rom[i] = 8'(i * 3 + 7);
    rom[0]  = 8'h10; rom[1]  = 8'h80; rom[8]  = 8'h20; rom[9]  = 8'h05;
    rom[2]  = 8'd10; rom[3]  = 8'd11; rom[10] = 8'd12; rom[11] = 8'd13;
    rom[4]  = 8'd200; rom[5] = 8'd3;  rom[12] = 8'd7;  rom[13] = 8'd9;
    rom[20] = 8'd1; rom[21] = 8'd2; rom[28] = 8'd3; rom[29] = 8'd4;
    rom[18] = 8'd1; rom[19] = 8'd2; rom[26] = 8'd3; rom[27] = 8'd4;
    rom[16] = 8'd1; rom[17] = 8'd2; rom[24] = 8'd3; rom[25] = 8'd4;
    rom[32] = 8'd1; rom[33] = 8'd2; rom[40] = 8'd3; rom[41] = 8'd4;
    rom[38] = 8'd50; rom[39] = 8'd60; rom[46] = 8'd70; rom[47] = 8'd80;
    rom[54] = 8'd9;  rom[55] = 8'd8;  rom[62] = 8'd7;  rom[63] = 8'd6;
    for (int i = 0; i < 64; i++) exp_img[i] = rom[i];

    reset = 1'b0;
    bus.cmd = 4'h0;
    bus.cmd_valid = 1'b0;
    bus.IROM_Q = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_rom_rd",  32'(bus.IROM_rd),    32'd0);
    check("rst_rom_a",   32'(bus.IROM_A),     32'd0);
    check("rst_ram_vld", 32'(bus.IRAM_valid), 32'd0);
    check("rst_ram_d",   32'(bus.IRAM_D),     32'd0);
    check("rst_ram_a",   32'(bus.IRAM_A),     32'd0);
    check("rst_busy",    32'(bus.busy),       32'd1);
    check("rst_done",    32'(bus.done),       32'd0);

    do_load();
    write_expect();                       // ROM image passes through unchanged

    shift(4'h1, 5);                       // y 4->1, saturates
    shift(4'h3, 4);                       // x 4->1, saturates
    send_cmd(4'h5);                       // Max at 0,1,8,9
    set4(0, 1, 8, 9, 8'h80, 8'h80, 8'h80, 8'h80);
    shift(4'h4, 2);                       // x=3
    send_cmd(4'h7);                       // Average 10,11,12,13
    set4(2, 3, 10, 11, 8'd11, 8'd11, 8'd11, 8'd11);
    shift(4'h4, 2);                       // x=5
    send_cmd(4'h6);                       // Min 200,3,7,9
    set4(4, 5, 12, 13, 8'd3, 8'd3, 8'd3, 8'd3);
    shift(4'h2, 2);                       // y=3
    send_cmd(4'h8);                       // CCW
    set4(20, 21, 28, 29, 8'd2, 8'd4, 8'd1, 8'd3);
    shift(4'h3, 2);                       // x=3
    send_cmd(4'h9);                       // CW
    set4(18, 19, 26, 27, 8'd3, 8'd1, 8'd4, 8'd2);
    shift(4'h3, 2);                       // x=1
    send_cmd(4'hA);                       // Mirror X
    set4(16, 17, 24, 25, 8'd3, 8'd4, 8'd1, 8'd2);
    shift(4'h2, 2);                       // y=5
    send_cmd(4'hB);                       // Mirror Y
    set4(32, 33, 40, 41, 8'd2, 8'd1, 8'd4, 8'd3);
    shift(4'h4, 3);                       // x=4
    shift(4'h4, 5);                       // x saturates at 7
    send_cmd(4'h5);                       // Max at cols 6,7
    set4(38, 39, 46, 47, 8'd80, 8'd80, 8'd80, 8'd80);
    shift(4'h2, 3);                       // y saturates at 7
    send_cmd(4'h6);                       // Min at 54,55,62,63
    set4(54, 55, 62, 63, 8'd6, 8'd6, 8'd6, 8'd6);
    send_cmd(4'hC);
    send_cmd(4'hF);
    write_expect();

    // Abort a write with reset at IRAM_A=20
    for (int i = 0; i < 20; i++) exp_q.push_back('{a: 6'(i), d: exp_img[i]});
    send_cmd(4'h0);
    n = 0;
    while (!(bus.IRAM_valid && bus.IRAM_A == 6'd20) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_reach_20", 32'(n < 200), 32'd1);
    #2;
    dsave = done_seen;
    reset = 1'b0;
    #1;
    check("abort_ram_vld", 32'(bus.IRAM_valid), 32'd0);
    check("abort_busy",    32'(bus.busy),       32'd1);
    check("abort_done",    32'(bus.done),       32'd0);
    check("abort_rom_rd",  32'(bus.IROM_rd),    32'd0);
    repeat (4) @(negedge clk);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);
    check("abort_no_done", 32'(done_seen), 32'(dsave));

    for (int i = 0; i < 64; i++) exp_img[i] = rom[i];
    do_load();
    write_expect();                       // image reloaded from ROM

    check("done_total", 32'(done_seen), 32'd3);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
